mul_seq: RTL and testbench
==========================

// Module: mul_seq
// PURPOSE
//  Sequential shift-add multiplier; the multiply counterpart of the
//  shift-subtract divider (div).
//  - Loads two N-bit unsigned operands on ld and forms the 2N-bit product in
//    exactly N cycles, one multiplier bit per cycle.
//  - Exposes its working registers ra/rb/ry with the same names and widths as
//    div, so the same bench can drive it and waveforms read the same way.
// PARAMETERS
//  N   4   operand width; product width is 2N; N >= 2
// PORTS
//  clk   in   1    single clock; all state updates on rising edge
//  rst   in   1    reset, synchronous, active-high
//  ld    in   1    load pulse; accepted only in IDLE or DONE
//  a     in   N    multiplicand, unsigned
//  b     in   N    multiplier, unsigned
//  ra    out  2N   accumulator; holds the final product once in DONE
//  rb    out  2N   shifted multiplicand
//  ry    out  N    remaining multiplier bits, shifted right each step
//  busy  out  1    1 while in RUN
//  done  out  1    1 while in DONE; held until the next accepted ld or rst
// BEHAVIOUR
//  - Reset: rst=1 at a clock edge -> state=IDLE, ra=0, rb=0, ry=0, cnt=0,
//    busy=0, done=0. rst overrides ld and any step in progress.
//    rst mid-RUN discards the operation; there is no partial result.
//  - FSM states: IDLE, RUN, DONE. All outputs are registered.
//    - IDLE/DONE, ld=1 -> RUN: ra<=0; rb<={N'b0,a}; ry<=b; cnt<=0; done<=0.
//    - IDLE, ld=0 -> hold IDLE. DONE, ld=0 -> hold DONE with result stable.
//    - RUN, each cycle:
//      - if ry[0]: ra <= ra + rb (2N-bit add, never overflows);
//      - rb <= rb << 1 (MSB dropped); ry <= ry >> 1 (zero fill); cnt <= cnt+1.
//    - RUN, cnt==N-1 -> this step is the last -> DONE, done<=1, busy<=0.
//  - ld during RUN is ignored; operands and progress are unaffected.
//  - a and b are sampled only on the accepting edge; later changes are ignored.
//  - Latency: ld accepted at edge k -> ra=a*b and done=1 after edge k+N.
//    Fixed at N steps, with no early exit even when ry becomes 0.
//  - Back-to-back: ld=1 while in DONE restarts in the same manner as from
//    IDLE; done drops on that edge.
//  - cnt width is clog2(N)+1 bits. cnt is internal and not a port.
//  - Zero operands: the FSM still runs N steps and ra ends at 0.
// STRUCTURE
//  - Shared package mul_pkg:
//    - state typedef {IDLE, RUN, DONE}
//    - localparam CNT_W = $clog2(N)+1
//    - the same package is reused by div for its FSM encoding.
//  - Single module: FSM plus datapath, about 150 lines.
//  - The datapath step is a natural optional sub-module, mul_step:
//    combinational (ra,rb,ry) -> next (ra,rb,ry).
// TESTING
//  Bench: 20-unit clock period, driven in the same style as the div bench.
//  1) a=4'b1011, b=4'b0010, ld pulse one cycle -> busy for 4 cycles,
//     then ra=8'h16, done=1, ry=0.
//  2) a=15, b=15 -> ra=8'hE1 after 4 cycles; no overflow.
//  3) a=0, b=9 and a=7, b=0 -> ra=0, done asserted after exactly 4 cycles.
//  4) a=3, b=5, then ld=1 with a=9, b=9 at cycle 2 of RUN -> ignored;
//     ra=8'h0F.
//  5) rst=1 at cycle 2 of RUN -> next edge all outputs 0, IDLE;
//     a fresh ld of 6*7 -> ra=8'h2A.
//  6) In DONE with ra=8'h16, ld with a=5, b=3 -> done=0 next edge,
//     then ra=8'h0F after 4 cycles.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared FSM encoding and counter sizing for the sequential multiplier (and divider).
package mul_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam int N_DEF = 4;
    localparam int CNT_W = $clog2(N_DEF) + 1;

    // Step-counter width for an arbitrary operand width n.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/mul_seq_if.sv
// Operand/result bundle for mul_seq; the bench drives the master side.
interface mul_seq_if #(parameter int N = 4);
    logic           ld;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] ra;
    logic [2*N-1:0] rb;
    logic [N-1:0]   ry;
    logic           busy;
    logic           done;

    modport master (output ld, a, b, input ra, rb, ry, busy, done);
    modport slave  (input ld, a, b, output ra, rb, ry, busy, done);
endinterface

// File: rtl/mul_seq_step.sv
// One shift-add step: conditionally accumulate, then advance multiplicand and multiplier.
module mul_step #(
    parameter int N = 4
) (
    input  logic [2*N-1:0] ra_i,
    input  logic [2*N-1:0] rb_i,
    input  logic [N-1:0]   ry_i,
    output logic [2*N-1:0] ra_o,
    output logic [2*N-1:0] rb_o,
    output logic [N-1:0]   ry_o
);
    // Product fits in 2N bits, so the add cannot overflow.
    assign ra_o = ry_i[0] ? ra_i + rb_i : ra_i;
    assign rb_o = rb_i << 1;
    assign ry_o = ry_i >> 1;
endmodule

// File: rtl/mul_seq.sv
// Sequential shift-add multiplier: N-bit unsigned a*b in exactly N RUN cycles.
module mul_seq
    import mul_pkg::*;
#(
    parameter int N = 4
) (
    input logic       clk,
    input logic       rst,
    mul_seq_if.slave  bus
);
    localparam int CW = cnt_w(N);

    state_e         state_q;
    logic [2*N-1:0] ra_q, rb_q, ra_d, rb_d;
    logic [N-1:0]   ry_q, ry_d;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, done_q;

    mul_step #(.N(N)) u_step (
        .ra_i (ra_q), .rb_i (rb_q), .ry_i (ry_q),
        .ra_o (ra_d), .rb_o (rb_d), .ry_o (ry_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.ld) begin
                        state_q <= RUN;
                        ra_q    <= '0;
                        rb_q    <= {{N{1'b0}}, bus.a};
                        ry_q    <= bus.b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    // Fixed N steps; no early exit when ry runs out of ones.
                    ra_q  <= ra_d;
                    rb_q  <= rb_d;
                    ry_q  <= ry_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ra   = ra_q;
    assign bus.rb   = rb_q;
    assign bus.ry   = ry_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: products queued at load, popped when done rises.
module tb_mul_seq;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [2*N-1:0] exp_q[$];

    mul_seq_if #(.N(N)) bus ();

    mul_seq #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    function automatic logic [2*N-1:0] prod(input logic [N-1:0] x, input logic [N-1:0] y);
        return (2*N)'(x) * (2*N)'(y);
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.ld = 1'b0; bus.a = '0; bus.b = '0;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({bus.ra, bus.rb, bus.ry, bus.busy, bus.done} !== '0) begin
            fails++;
            $display("FAIL reset: ra=%h rb=%h ry=%h busy=%b done=%b, want all 0",
                     bus.ra, bus.rb, bus.ry, bus.busy, bus.done);
        end
        rst = 1'b0;
    endtask

    // Load one operation and follow it cycle by cycle to DONE.
    task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input string nm);
        logic [2*N-1:0] exp_p;
        @(negedge clk);
        bus.ld = 1'b1; bus.a = x; bus.b = y;
        exp_q.push_back(prod(x, y));
        @(negedge clk);
        bus.ld = 1'b0; bus.a = N'($urandom); bus.b = N'($urandom);
        for (int s = 0; s < N; s++) begin
            tests++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                fails++;
                $display("FAIL %s run step %0d: busy=%b done=%b, want busy=1 done=0",
                         nm, s, bus.busy, bus.done);
            end
            @(negedge clk);
        end
        exp_p = exp_q.pop_front();
        tests++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done: busy=%b done=%b, want busy=0 done=1", nm, bus.busy, bus.done);
        end
        tests++;
        if (bus.ra !== exp_p || bus.ry !== '0 || bus.rb !== {x, {N{1'b0}}}) begin
            fails++;
            $display("FAIL %s result: ra=%h ry=%h rb=%h, want ra=%h ry=0 rb=%h",
                     nm, bus.ra, bus.ry, bus.rb, exp_p, {x, {N{1'b0}}});
        end
    endtask

    task automatic test_basic();
        run_op(4'b1011, 4'b0010, "basic");
        tests++;
        if (bus.ra !== 8'h16) begin
            fails++;
            $display("FAIL basic const: ra=%h want 16", bus.ra);
        end
        run_op(4'd15, 4'd15, "max");
        tests++;
        if (bus.ra !== 8'hE1) begin
            fails++;
            $display("FAIL max const: ra=%h want e1", bus.ra);
        end
    endtask

    task automatic test_zero();
        run_op(4'd0, 4'd9, "zero_a");
        run_op(4'd7, 4'd0, "zero_b");
    endtask

    task automatic test_ld_ignored();
        @(negedge clk);
        bus.ld = 1'b1; bus.a = 4'd3; bus.b = 4'd5;
        exp_q.push_back(prod(4'd3, 4'd5));
        @(negedge clk);
        bus.ld = 1'b0;
        @(negedge clk);
        bus.ld = 1'b1; bus.a = 4'd9; bus.b = 4'd9;
        @(negedge clk);
        bus.ld = 1'b0;
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL ld_ignored busy: busy=%b want 1", bus.busy);
        end
        @(negedge clk); @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.ra !== exp_q.pop_front() || bus.ra !== 8'h0F) begin
            fails++;
            $display("FAIL ld_ignored result: done=%b ra=%h want done=1 ra=0f", bus.done, bus.ra);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.ld = 1'b1; bus.a = 4'd3; bus.b = 4'd5;
        @(negedge clk);
        bus.ld = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({bus.ra, bus.rb, bus.ry, bus.busy, bus.done} !== '0) begin
            fails++;
            $display("FAIL mid_reset: ra=%h rb=%h ry=%h busy=%b done=%b, want all 0",
                     bus.ra, bus.rb, bus.ry, bus.busy, bus.done);
        end
        rst = 1'b0;
        run_op(4'd6, 4'd7, "after_reset");
        tests++;
        if (bus.ra !== 8'h2A) begin
            fails++;
            $display("FAIL after_reset const: ra=%h want 2a", bus.ra);
        end
    endtask

    task automatic test_back_to_back();
        run_op(4'b1011, 4'b0010, "b2b_first");
        @(negedge clk);
        tests++;
        if (bus.done !== 1'b1 || bus.ra !== 8'h16) begin
            fails++;
            $display("FAIL b2b_hold: done=%b ra=%h want done=1 ra=16", bus.done, bus.ra);
        end
        run_op(4'd5, 4'd3, "b2b_second");
        tests++;
        if (bus.ra !== 8'h0F) begin
            fails++;
            $display("FAIL b2b const: ra=%h want 0f", bus.ra);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_op(N'($urandom), N'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_ld_ignored();
        test_mid_reset();
        test_back_to_back();
        test_random();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
